// File: rtl/alu_mc_pkg.sv
// Shared op-code and FSM state definitions for the multi-cycle ALU.
package alu_mc_pkg;

  typedef enum logic [2:0] {
    OP_RSV = 3'b000,
    OP_AND = 3'b001,
    OP_OR  = 3'b010,
    OP_ADD = 3'b011,
    OP_SUB = 3'b100,
    OP_NOR = 3'b101,
    OP_SLT = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // SUB and SLT both run the adder as A + ~B + 1.
  function automatic logic op_subtracts(op_e op);
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Request/response bundle between the register-file read side and the ALU.
interface alu_mc_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start_i;
  logic [2:0]       op_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;
  logic [WIDTH-1:0] result_hi_o;
  logic             zero_o;
  logic             cout_o;
  logic             overflow_o;

  modport master (
    output start_i, op_i, src1_i, src2_i,
    input  busy_o, done_o, result_o, result_hi_o, zero_o, cout_o, overflow_o
  );

  modport slave (
    input  start_i, op_i, src1_i, src2_i,
    output busy_o, done_o, result_o, result_hi_o, zero_o, cout_o, overflow_o
  );
endinterface

// File: rtl/alu_mc_mul_shift_add.sv
// Iterative unsigned shift-add multiplier: one partial product per step.
module mul_shift_add #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   mcand_i,
  input  logic [WIDTH-1:0]   mplier_i,
  output logic               last_o,
  output logic [2*WIDTH-1:0] prod_nxt_o
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     upper;

  // Low half of the accumulator starts as the multiplier and is consumed LSB first
  // while the product grows into the upper half from the left.
  always_comb begin
    addend     = acc_q[0] ? mcand_q : '0;
    upper      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    prod_nxt_o = {upper, acc_q[WIDTH-1:1]};
  end

  assign last_o = step_i && (cnt_q == CW'(WIDTH - 1));

  // Operand load on accept, one shift-add per step.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
    end else if (load_i) begin
      cnt_q   <= '0;
      mcand_q <= mcand_i;
      acc_q   <= {{WIDTH{1'b0}}, mplier_i};
    end else if (step_i) begin
      cnt_q   <= cnt_q + CW'(1);
      acc_q   <= prod_nxt_o;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative unsigned multiply,
// with a start/busy/done handshake that allows issue in the DONE cycle.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic     clk_i,
  input  logic     rst_i,
  alu_mc_if.slave  bus
);

  state_e             state_q, state_d;
  op_e                op;
  logic               is_mul;
  logic               accept;
  logic               mul_last;
  logic [WIDTH-1:0]   a, b, b_eff, sum;
  logic               carry, ovf_add, sub_mode;
  logic [WIDTH-1:0]   res_d;
  logic               cout_d, ovf_d;
  logic [2*WIDTH-1:0] prod_nxt;
  logic [WIDTH-1:0]   result_q, result_hi_q;
  logic               cout_q, ovf_q;

  assign op       = op_e'(bus.op_i);
  assign a        = bus.src1_i;
  assign b        = bus.src2_i;
  assign is_mul   = MUL_EN && (op == OP_MUL);
  assign accept   = bus.start_i && (state_q != ST_MUL);
  assign sub_mode = op_subtracts(op);

  // Shared adder: SUB/SLT use the inverted operand with carry-in 1.
  always_comb begin
    b_eff        = sub_mode ? ~b : b;
    {carry, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_mode};
    ovf_add      = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

  // Single-cycle result selection; reserved codes produce zero.
  always_comb begin
    res_d  = '0;
    cout_d = 1'b0;
    ovf_d  = 1'b0;
    case (op)
      OP_AND: res_d = a & b;
      OP_OR:  res_d = a | b;
      OP_NOR: res_d = ~(a | b);
      OP_ADD, OP_SUB: begin
        res_d  = sum;
        cout_d = carry;
        ovf_d  = ovf_add;
      end
      // Sign of the difference corrected by overflow gives the true signed compare.
      OP_SLT: res_d = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf_add};
      default: res_d = '0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: IDLE and DONE both accept, so ops can issue back-to-back.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start_i) state_d = is_mul ? ST_MUL : ST_DONE;
        else             state_d = ST_IDLE;
      end
      ST_MUL: if (mul_last) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  mul_shift_add #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (accept && is_mul),
    .step_i     (state_q == ST_MUL),
    .mcand_i    (a),
    .mplier_i   (b),
    .last_o     (mul_last),
    .prod_nxt_o (prod_nxt)
  );

  // Result registers update only when an op completes, so they hold through MUL.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      result_q    <= '0;
      result_hi_q <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (accept && !is_mul) begin
      result_q    <= res_d;
      result_hi_q <= '0;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
    end else if (mul_last) begin
      result_q    <= prod_nxt[WIDTH-1:0];
      result_hi_q <= prod_nxt[2*WIDTH-1:WIDTH];
      cout_q      <= 1'b0;
      ovf_q       <= |prod_nxt[2*WIDTH-1:WIDTH];
    end
  end

  assign bus.busy_o      = (state_q == ST_MUL);
  assign bus.done_o      = (state_q == ST_DONE);
  assign bus.result_o    = result_q;
  assign bus.result_hi_o = result_hi_q;
  assign bus.zero_o      = (result_q == '0);
  assign bus.cout_o      = cout_q;
  assign bus.overflow_o  = ovf_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc at WIDTH=32 and WIDTH=8.
module tb_alu_mc;
  import alu_mc_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  alu_mc_if #(.WIDTH(32)) if32 ();
  alu_mc_if #(.WIDTH(8))  if8 ();

  alu_mc #(.WIDTH(32), .MUL_EN(1'b1)) dut32 (.clk_i(clk), .rst_i(rst), .bus(if32.slave));
  alu_mc #(.WIDTH(8),  .MUL_EN(1'b1)) dut8  (.clk_i(clk), .rst_i(rst), .bus(if8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue32(input op_e op, input logic [31:0] x, input logic [31:0] y);
    if32.start_i = 1'b1;
    if32.op_i    = op;
    if32.src1_i  = x;
    if32.src2_i  = y;
    tick();
    if32.start_i = 1'b0;
  endtask

  task automatic issue8(input op_e op, input logic [7:0] x, input logic [7:0] y);
    if8.start_i = 1'b1;
    if8.op_i    = op;
    if8.src1_i  = x;
    if8.src2_i  = y;
    tick();
    if8.start_i = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    if32.start_i = 1'b0; if32.op_i = 3'b000; if32.src1_i = '0; if32.src2_i = '0;
    if8.start_i  = 1'b0; if8.op_i  = 3'b000; if8.src1_i  = '0; if8.src2_i  = '0;

    // Reset: two cycles high, then released.
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_busy",   64'(if32.busy_o),   64'd0);
    check("rst_done",   64'(if32.done_o),   64'd0);
    check("rst_result", 64'(if32.result_o), 64'd0);
    check("rst_zero",   64'(if32.zero_o),   64'd1);
    check("rst_ovf",    64'(if32.overflow_o), 64'd0);
    check("rst8_busy",  64'(if8.busy_o),    64'd0);

    // ADD signed overflow, latency 1.
    issue32(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    check("add_done",   64'(if32.done_o),     64'd1);
    check("add_busy",   64'(if32.busy_o),     64'd0);
    check("add_result", 64'(if32.result_o),   64'h8000_0000);
    check("add_ovf",    64'(if32.overflow_o), 64'd1);
    check("add_cout",   64'(if32.cout_o),     64'd0);
    check("add_hi",     64'(if32.result_hi_o), 64'd0);
    tick();
    check("add_done_drop", 64'(if32.done_o),   64'd0);
    check("add_hold",      64'(if32.result_o), 64'h8000_0000);

    // ADD with carry out wrapping to zero.
    issue32(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
    check("addc_result", 64'(if32.result_o),   64'd0);
    check("addc_cout",   64'(if32.cout_o),     64'd1);
    check("addc_ovf",    64'(if32.overflow_o), 64'd0);
    check("addc_zero",   64'(if32.zero_o),     64'd1);

    // SUB 5-5, then back-to-back SUB 3-5 accepted in the DONE cycle.
    issue32(OP_SUB, 32'd5, 32'd5);
    check("sub_result", 64'(if32.result_o), 64'd0);
    check("sub_zero",   64'(if32.zero_o),   64'd1);
    check("sub_cout",   64'(if32.cout_o),   64'd1);
    check("sub_done",   64'(if32.done_o),   64'd1);
    issue32(OP_SUB, 32'd3, 32'd5);
    check("sub2_done",   64'(if32.done_o),     64'd1);
    check("sub2_result", 64'(if32.result_o),   64'hFFFF_FFFE);
    check("sub2_cout",   64'(if32.cout_o),     64'd0);
    check("sub2_ovf",    64'(if32.overflow_o), 64'd0);
    check("sub2_zero",   64'(if32.zero_o),     64'd0);

    // SLT: overflowing compare and negative operand B.
    issue32(OP_SLT, 32'h8000_0000, 32'h0000_0001);
    check("slt_ovf_result", 64'(if32.result_o),   64'd1);
    check("slt_ovf_flag",   64'(if32.overflow_o), 64'd0);
    check("slt_cout",       64'(if32.cout_o),     64'd0);
    issue32(OP_SLT, 32'h0000_0001, 32'hFFFF_FFFF);
    check("slt_neg_result", 64'(if32.result_o), 64'd0);
    check("slt_neg_zero",   64'(if32.zero_o),   64'd1);

    // Bitwise ops and reserved code.
    issue32(OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00);
    check("and_result", 64'(if32.result_o), 64'h00F0_1200);
    issue32(OP_OR, 32'hF000_000F, 32'h0000_F0F0);
    check("or_result", 64'(if32.result_o), 64'hF000_F0FF);
    issue32(OP_NOR, 32'hF0F0_F0F0, 32'h0F0F_0000);
    check("nor_result", 64'(if32.result_o), 64'h0000_0F0F);
    issue32(OP_RSV, 32'h1234_5678, 32'h9ABC_DEF0);
    check("rsv_result", 64'(if32.result_o), 64'd0);
    check("rsv_zero",   64'(if32.zero_o),   64'd1);

    // W=8: known result held through a MUL; mid-MUL start pulses ignored.
    issue8(OP_AND, 8'h0F, 8'h3C);
    check("and8_result", 64'(if8.result_o), 64'h0C);
    tick();
    issue8(OP_MUL, 8'hFF, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("mul_busy_%0d", i),  64'(if8.busy_o),   64'd1);
      check($sformatf("mul_done_%0d", i),  64'(if8.done_o),   64'd0);
      check($sformatf("mul_hold_%0d", i),  64'(if8.result_o), 64'h0C);
      if (i == 3) begin
        if8.start_i = 1'b1;
        if8.op_i    = OP_ADD;
        if8.src1_i  = 8'h01;
        if8.src2_i  = 8'h01;
      end
      tick();
      if8.start_i = 1'b0;
    end
    check("mul_done",   64'(if8.done_o),      64'd1);
    check("mul_busy_end", 64'(if8.busy_o),    64'd0);
    check("mul_lo",     64'(if8.result_o),    64'h01);
    check("mul_hi",     64'(if8.result_hi_o), 64'hFE);
    check("mul_ovf",    64'(if8.overflow_o),  64'd1);
    check("mul_cout",   64'(if8.cout_o),      64'd0);
    check("mul_zero",   64'(if8.zero_o),      64'd0);

    // ADD accepted in the MUL's DONE cycle.
    issue8(OP_ADD, 8'h10, 8'h20);
    check("b2b_done",   64'(if8.done_o),      64'd1);
    check("b2b_result", 64'(if8.result_o),    64'h30);
    check("b2b_hi",     64'(if8.result_hi_o), 64'h00);
    check("b2b_ovf",    64'(if8.overflow_o),  64'd0);
    tick();
    check("b2b_gap_done", 64'(if8.done_o),   64'd0);
    check("b2b_gap_hold", 64'(if8.result_o), 64'h30);
    tick();
    check("b2b_idle_hold", 64'(if8.result_o), 64'h30);

    // Reset during MUL: aborts, clears outputs, no done.
    issue8(OP_MUL, 8'hAA, 8'h55);
    tick();
    tick();
    tick();
    check("abort_busy_pre", 64'(if8.busy_o), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy",   64'(if8.busy_o),      64'd0);
    check("abort_done",   64'(if8.done_o),      64'd0);
    check("abort_result", 64'(if8.result_o),    64'd0);
    check("abort_hi",     64'(if8.result_hi_o), 64'd0);
    check("abort_zero",   64'(if8.zero_o),      64'd1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("abort_nodone_%0d", i), 64'(if8.done_o), 64'd0);
    end

    // MUL 3*4 after the abort.
    issue8(OP_MUL, 8'd3, 8'd4);
    for (int i = 0; i < 8; i++) tick();
    check("mul34_done",   64'(if8.done_o),      64'd1);
    check("mul34_result", 64'(if8.result_o),    64'd12);
    check("mul34_hi",     64'(if8.result_hi_o), 64'd0);
    check("mul34_ovf",    64'(if8.overflow_o),  64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
